// File: rtl/chronos_fetch.sv
// chronos_fetch: instruction-fetch stage of the chronos RV32I core.
//
// Owns the PC, issues word-aligned fetches to instruction memory and buffers
// in-order responses in a 2-entry output queue feeding decode. A redirect
// from execute flushes the queue and turns every outstanding fetch stale.
// Stale responses are then counted down and dropped.
//
// Ports
//   clk             core clock, rising edge
//   rst             asynchronous reset, active low
//   imem_req_valid  fetch request valid
//   imem_req_ready  memory accepts the request
//   imem_req_addr   fetch address, word aligned
//   imem_rsp_valid  in-order response valid (cannot be backpressured)
//   imem_rsp_data   instruction word
//   redirect_valid  control-flow redirect from execute
//   redirect_pc     redirect target (bits [1:0] ignored)
//   dcd_valid       {dcd_pc, dcd_inst} valid to decode
//   dcd_ready       decode accepts
//   dcd_pc          PC of the presented instruction
//   dcd_inst        presented instruction (NOP_INST when not valid)
module chronos_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dcd_valid,
  input  logic        dcd_ready,
  output logic [31:0] dcd_pc,
  output logic [31:0] dcd_inst
);

  // Control state
  logic        r_run;
  logic [31:0] r_fetch_pc;
  logic [1:0]  r_count;
  logic [1:0]  r_live;
  logic [1:0]  r_drop;

  // Pending-PC queue (occupancy is r_live) and output queue (occupancy r_count)
  logic [31:0] r_pend0;
  logic [31:0] r_pend1;
  logic [31:0] r_q0_pc;
  logic [31:0] r_q0_inst;
  logic [31:0] r_q1_pc;
  logic [31:0] r_q1_inst;

  logic        w_deq;
  logic        w_acc;
  logic        w_keep;
  logic        w_enq;
  logic        w_stale_rsp;
  logic [2:0]  w_credit;
  logic [31:0] w_redir_pc;

  logic [31:0] w_fetch_pc_n;
  logic [1:0]  w_live_n;
  logic [1:0]  w_drop_n;
  logic [1:0]  w_count_n;
  logic [1:0]  w_cnt_mid;
  logic [1:0]  w_live_after_pop;
  logic [31:0] w_pend0_n;
  logic [31:0] w_pend1_n;
  logic [31:0] w_q0_pc_n;
  logic [31:0] w_q0_inst_n;
  logic [31:0] w_q1_pc_n;
  logic [31:0] w_q1_inst_n;

  assign w_redir_pc  = redirect_pc & 32'hFFFF_FFFC;

  assign dcd_valid   = (r_count != 2'd0) && !redirect_valid;
  assign w_deq       = dcd_valid && dcd_ready;
  assign dcd_pc      = r_q0_pc;
  assign dcd_inst    = dcd_valid ? r_q0_inst : NOP_INST;

  // Credit counts every slot a request could end up needing in the output
  // queue; a dequeue this cycle frees one immediately so 1-cycle memory
  // sustains one fetch per cycle.
  assign w_credit    = {1'b0, r_live} + {1'b0, r_drop} + {1'b0, r_count}
                     - {2'b00, w_deq};
  assign imem_req_valid = r_run && !redirect_valid && (w_credit < 3'd2);
  assign imem_req_addr  = r_fetch_pc;
  assign w_acc       = imem_req_valid && imem_req_ready;

  // A response either belongs to a live request (pops a pending PC) or to a
  // stale one (only decrements the drop count).
  assign w_keep      = imem_rsp_valid && (r_drop == 2'd0);
  assign w_stale_rsp = imem_rsp_valid && (r_drop != 2'd0);
  assign w_enq       = w_keep && !redirect_valid;

  always_comb begin
    w_fetch_pc_n = r_fetch_pc;
    if (redirect_valid) begin
      w_fetch_pc_n = w_redir_pc;
    end else if (w_acc) begin
      w_fetch_pc_n = r_fetch_pc + 32'd4;
    end
  end

  always_comb begin
    w_live_n = r_live + {1'b0, w_acc} - {1'b0, w_keep};
    w_drop_n = r_drop - {1'b0, w_stale_rsp};
    if (redirect_valid) begin
      // Everything still in flight after this cycle's response becomes stale.
      w_live_n = 2'd0;
      w_drop_n = r_drop - {1'b0, w_stale_rsp} + r_live - {1'b0, w_keep};
    end
  end

  always_comb begin
    w_live_after_pop = r_live - {1'b0, w_keep};
    w_pend0_n        = w_keep ? r_pend1 : r_pend0;
    w_pend1_n        = r_pend1;
    if (w_acc) begin
      if (w_live_after_pop == 2'd0) begin
        w_pend0_n = r_fetch_pc;
      end else begin
        w_pend1_n = r_fetch_pc;
      end
    end
  end

  always_comb begin
    w_q0_pc_n   = r_q0_pc;
    w_q0_inst_n = r_q0_inst;
    w_q1_pc_n   = r_q1_pc;
    w_q1_inst_n = r_q1_inst;
    w_cnt_mid   = r_count - {1'b0, w_deq};
    if (w_deq) begin
      w_q0_pc_n   = r_q1_pc;
      w_q0_inst_n = r_q1_inst;
    end
    w_count_n = w_cnt_mid;
    if (w_enq) begin
      if (w_cnt_mid == 2'd0) begin
        w_q0_pc_n   = r_pend0;
        w_q0_inst_n = imem_rsp_data;
      end else begin
        w_q1_pc_n   = r_pend0;
        w_q1_inst_n = imem_rsp_data;
      end
      w_count_n = w_cnt_mid + 2'd1;
    end
    if (redirect_valid) begin
      w_count_n = 2'd0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run      <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_count    <= 2'd0;
      r_live     <= 2'd0;
      r_drop     <= 2'd0;
      r_q0_pc    <= RESET_PC;
    end else begin
      r_run      <= 1'b1;
      r_fetch_pc <= w_fetch_pc_n;
      r_count    <= w_count_n;
      r_live     <= w_live_n;
      r_drop     <= w_drop_n;
      r_q0_pc    <= w_q0_pc_n;
    end
  end

  // Queue payload; only meaningful while the matching occupancy covers it.
  always_ff @(posedge clk) begin
    r_pend0   <= w_pend0_n;
    r_pend1   <= w_pend1_n;
    r_q0_inst <= w_q0_inst_n;
    r_q1_pc   <= w_q1_pc_n;
    r_q1_inst <= w_q1_inst_n;
  end

  a_no_queue_overflow: assert property (
    @(posedge clk) disable iff (!rst) !(w_enq && (w_cnt_mid == 2'd2)));

endmodule

// File: doc/chronos_fetch.md
# chronos_fetch

Instruction-fetch stage of the chronos RV32I core. It sits directly upstream of the decoder inside the CPU. It owns the PC, issues word-aligned requests to instruction memory over a valid/ready channel and buffers in-order responses in a 2-entry queue. It hands {pc, inst} to decode over a valid/ready channel and squashes wrong-path fetches on a redirect from execute.

## Interface

**Parameters**
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INST`, default 32'h0000_0013 (addi x0,x0,0): value driven on `dcd_inst` whenever `dcd_valid`=0.

**Ports** (name, direction, width, meaning)
- `clk` in 1: core clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_req_addr` out 32: fetch address. Bits [1:0] are always 0.
- `imem_rsp_valid` in 1: response data valid. Responses are in order, at least 1 cycle after acceptance, and cannot be backpressured.
- `imem_rsp_data` in 32: instruction word.
- `redirect_valid` in 1: control-flow redirect from execute (branch, jump).
- `redirect_pc` in 32: redirect target. Bits [1:0] are ignored and forced to 0.
- `dcd_valid` out 1: {`dcd_pc`, `dcd_inst`} valid to decode.
- `dcd_ready` in 1: decode accepts this cycle.
- `dcd_pc` out 32: PC of the presented instruction.
- `dcd_inst` out 32: presented instruction word.

## Operation

**State**
- `fetch_pc`: 32 bits.
- Pending-PC queue: 2 entries, holding the PC of each accepted, unreturned request.
- Output queue: 2 entries of {pc, inst}, with a `count` of 0..2.
- `live`: 0..2, outstanding non-stale requests.
- `drop`: 0..2, outstanding stale requests.

**Reset** (`rst`=0, asynchronous)
- `fetch_pc` = `RESET_PC`.
- `count`, `live`, `drop` = 0.
- Outputs: `imem_req_valid`=0, `dcd_valid`=0, `dcd_inst`=`NOP_INST`, `dcd_pc`=`RESET_PC`, `imem_req_addr`=`RESET_PC`.

**Issue**
- `imem_req_valid` = !redirect_valid && (live + drop + count − deq) < 2, where deq = `dcd_valid` && `dcd_ready`.
- `imem_req_addr` = `fetch_pc`.
- On accept (valid && ready): push `fetch_pc` to the pending-PC queue, `fetch_pc` += 4 (wraps modulo 2^32), `live`++.
- While valid && !ready, the address is held stable.

**Response**
- If `drop` > 0: discard the response and decrement `drop`.
- Otherwise: pop the pending PC, enqueue {pc, data}, decrement `live`.
- Because of the credit rule, a response never arrives with the queue full. An assertion flags a violation.

**Dequeue**
- `dcd_valid` = (count > 0) && !redirect_valid.
- Head entry drives `dcd_pc`/`dcd_inst`. It pops on deq.

**Redirect** (highest priority)
- Flush the output queue (`count`=0).
- `drop` += `live` + (response arriving this cycle with `drop`=0 ? −1 : 0). Then `live`=0 and the pending-PC queue is cleared.
- `fetch_pc` = {redirect_pc[31:2], 2'b00}.
- No request is issued in the redirect cycle.

**Simultaneous events**
- Enqueue and dequeue in the same cycle leave `count` unchanged.
- Redirect overrides enqueue, dequeue and issue in that cycle.
- A response arriving in the redirect cycle is discarded.

## Timing

- Fetch-to-decode latency: request accepted in cycle N, response in N+1 (minimum), `dcd_valid` in N+2. There is no bypass from response to decode.
- Sustained throughput is 1 instruction/cycle with 1-cycle memory and `dcd_ready`=1. This relies on deq freeing credit in the same cycle.
- Redirect in cycle R: first request at the redirect target in R+1, earliest `dcd_valid` for it in R+3.
- First request after reset release: `imem_req_valid`=1 in the first cycle after the first rising edge with `rst`=1.
- Combinational paths: `dcd_ready` → `imem_req_valid`, and `redirect_valid` → both valid outputs. No path from `imem_req_ready` to any output.
- Reset asserted mid-stream: all state clears immediately. Responses to pre-reset requests arriving after release are not the environment's concern; imem is reset together with the core.

## Test plan

1. **Reset fetch.** Hold `rst`=0 for 2 cycles, release, 1-cycle memory, `dcd_ready`=1.
   - `imem_req_addr` = 0x0, 0x4, 0x8… on consecutive cycles.
   - `dcd_pc` = 0x0 two cycles after the first accept, then +4 every cycle.
2. **Decode backpressure.** `dcd_ready`=0 for 5 cycles.
   - At most 2 requests accepted beyond the head.
   - `dcd_valid` stays 1 with `dcd_pc` stable.
   - On release, PCs resume in order with none skipped or duplicated.
3. **Memory stall.** `imem_req_ready`=0 for 3 cycles with `imem_req_valid`=1.
   - `imem_req_addr` holds (e.g. 0x10).
   - `fetch_pc` does not advance until accept.
4. **Redirect with 2 outstanding.** `redirect_pc`=0x103 with 2 outstanding requests.
   - Both stale responses are dropped.
   - Next `imem_req_addr`=0x100 in R+1.
   - First `dcd_pc` after the redirect is 0x100, with no stale PC ever presented.
5. **Redirect in the same cycle as response and dequeue.**
   - `dcd_valid`=0 that cycle and `count`=0 after.
   - Response discarded; next presented instruction comes from the target.
6. **Mid-stream reset and wrap.**
   - Assert `rst`=0 mid-stream: `dcd_valid` and `imem_req_valid` drop to 0 immediately, and `dcd_inst`=0x00000013.
   - With `RESET_PC`=32'hFFFF_FFFC, the second fetch address is 0x0.
